// File: rtl/div_sequencer.sv
// ----------------------------------------------------------------------------
// div_sequencer
//
// Multi-cycle controller and datapath for DIV/DIVU in the execute stage.
// A start pulse latches the operands. A radix-2 restoring division then runs
// for DATA_W iterations while the upstream pipeline is stalled. The remainder
// (HI) and quotient (LO) are presented together with a one-cycle ready strobe.
//
// Ports
//   clk       in   system clock, rising edge
//   resetn    in   asynchronous active-low reset
//   start_i   in   execute stage holds a DIV/DIVU instruction
//   signed_i  in   1 = DIV (signed), 0 = DIVU; sampled with start_i
//   a_i       in   dividend (rs), DATA_W bits
//   b_i       in   divisor (rt), DATA_W bits
//   annul_i   in   flush; cancels any operation in flight
//   stall_o   out  freeze pipeline up to and including execute (combinational)
//   ready_o   out  one-cycle completion strobe (registered)
//   result_o  out  {remainder, quotient} = {HI, LO} (registered, held)
// ----------------------------------------------------------------------------
module div_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    input  logic                  annul_i,
    output logic                  stall_o,
    output logic                  ready_o,
    output logic [2*DATA_W-1:0]   result_o
);

    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_ON   = 2'd2,
        DIV_END  = 2'd3
    } state_t;

    // Two's-complement negate.
    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return (~v) + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    state_t                 state_r;
    logic [CW-1:0]          cnt_r;
    logic [DATA_W-1:0]      rem_r;      // partial remainder
    logic [DATA_W-1:0]      quo_r;      // dividend magnitude shifting out, quotient shifting in
    logic [DATA_W-1:0]      dvs_r;      // divisor magnitude
    logic [DATA_W-1:0]      a_raw_r;    // raw dividend, used as remainder on divide-by-zero
    logic                   signed_r;
    logic                   sign_a_r;
    logic                   sign_b_r;
    logic                   ready_r;
    logic [2*DATA_W-1:0]    result_r;

    logic [DATA_W-1:0]      a_mag_s;
    logic [DATA_W-1:0]      b_mag_s;
    logic [DATA_W:0]        rem_shift_s;
    logic [DATA_W+1:0]      sub_s;
    logic                   borrow_s;
    logic [DATA_W-1:0]      rem_next_s;
    logic [DATA_W-1:0]      quo_next_s;
    logic [DATA_W-1:0]      rem_fix_s;
    logic [DATA_W-1:0]      quo_fix_s;
    logic                   last_iter_s;
    logic                   stall_s;

    // Operand magnitudes at start; 0x80..0 negates to itself and is read as unsigned 2^(W-1).
    always_comb begin
        a_mag_s = a_i;
        b_mag_s = b_i;
        if (signed_i && a_i[DATA_W-1]) begin
            a_mag_s = negate(a_i);
        end else begin
            a_mag_s = a_i;
        end
        if (signed_i && b_i[DATA_W-1]) begin
            b_mag_s = negate(b_i);
        end else begin
            b_mag_s = b_i;
        end
    end

    // One restoring iteration plus the signed fixup applied to its outcome.
    always_comb begin
        rem_shift_s = {rem_r, quo_r[DATA_W-1]};
        // Extra top bit so the borrow of the (DATA_W+1)-bit trial subtract is explicit.
        sub_s       = {1'b0, rem_shift_s} - {2'b00, dvs_r};
        borrow_s    = sub_s[DATA_W+1];
        if (borrow_s) begin
            rem_next_s = rem_shift_s[DATA_W-1:0];
        end else begin
            rem_next_s = sub_s[DATA_W-1:0];
        end
        quo_next_s = {quo_r[DATA_W-2:0], ~borrow_s};
        if (signed_r && (sign_a_r ^ sign_b_r)) begin
            quo_fix_s = negate(quo_next_s);
        end else begin
            quo_fix_s = quo_next_s;
        end
        if (signed_r && sign_a_r) begin
            rem_fix_s = negate(rem_next_s);
        end else begin
            rem_fix_s = rem_next_s;
        end
        last_iter_s = (cnt_r == CW'(DATA_W - 1));
    end

    // Pipeline stall: low in DIV_END so the stalled instruction advances with ready.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            IDLE:     stall_s = start_i & ~annul_i;
            DIV_ON,
            DIV_ZERO: stall_s = ~annul_i;
            default:  stall_s = 1'b0;
        endcase
    end

    // Sequencer state, iteration datapath and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r  <= IDLE;
            cnt_r    <= {CW{1'b0}};
            rem_r    <= {DATA_W{1'b0}};
            quo_r    <= {DATA_W{1'b0}};
            dvs_r    <= {DATA_W{1'b0}};
            a_raw_r  <= {DATA_W{1'b0}};
            signed_r <= 1'b0;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            ready_r  <= 1'b0;
            result_r <= {(2*DATA_W){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    ready_r <= 1'b0;
                    if (start_i && !annul_i) begin
                        cnt_r    <= {CW{1'b0}};
                        rem_r    <= {DATA_W{1'b0}};
                        quo_r    <= a_mag_s;
                        dvs_r    <= b_mag_s;
                        a_raw_r  <= a_i;
                        signed_r <= signed_i;
                        sign_a_r <= a_i[DATA_W-1];
                        sign_b_r <= b_i[DATA_W-1];
                        if (b_i == {DATA_W{1'b0}}) begin
                            state_r <= DIV_ZERO;
                        end else begin
                            state_r <= DIV_ON;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DIV_ZERO: begin
                    if (annul_i) begin
                        state_r <= IDLE;
                        ready_r <= 1'b0;
                    end else begin
                        state_r  <= DIV_END;
                        ready_r  <= 1'b1;
                        result_r <= {a_raw_r, {DATA_W{1'b1}}};
                    end
                end
                DIV_ON: begin
                    if (annul_i) begin
                        state_r <= IDLE;
                        ready_r <= 1'b0;
                    end else begin
                        rem_r <= rem_next_s;
                        quo_r <= quo_next_s;
                        cnt_r <= cnt_r + CW'(1);
                        if (last_iter_s) begin
                            state_r  <= DIV_END;
                            ready_r  <= 1'b1;
                            result_r <= {rem_fix_s, quo_fix_s};
                        end else begin
                            state_r <= DIV_ON;
                            ready_r <= 1'b0;
                        end
                    end
                end
                DIV_END: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign stall_o  = stall_s;
    assign ready_o  = ready_r;
    assign result_o = result_r;

endmodule
